// File: rtl/mea_pkg.sv
// Shared state encoding, default write-window timing and the window compare helper
// for the pixel SRAM write path.
package mea_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_PIX = 3'd1,
      PULSE    = 3'd2,
      NEXT     = 3'd3,
      DONE     = 3'd4
   } seq_state_t;

   localparam int unsigned DEF_WINDOW = 10;
   localparam int unsigned DEF_D1_ON  = 1;
   localparam int unsigned DEF_D1_OFF = 4;
   localparam int unsigned DEF_D2_ON  = 2;
   localparam int unsigned DEF_D2_OFF = 6;
   localparam int unsigned DEF_WE_ON  = 2;
   localparam int unsigned DEF_WE_OFF = 8;

   function automatic logic in_window(input int unsigned t, input int unsigned on,
                                      input int unsigned off);
      return (t >= on) && (t < off);
   endfunction

endpackage

// File: rtl/pixel_pulse_gen.sv
// Per-pixel write window: tick counter plus registered WE/D1/D2 compares.
// Outputs lag tick by one clk so the pin waveform is glitch-free.
module pixel_pulse_gen
   import mea_pkg::*;
#(
   parameter int unsigned TICK_W = 4,
   parameter int unsigned WINDOW = DEF_WINDOW,
   parameter int unsigned D1_ON  = DEF_D1_ON,
   parameter int unsigned D1_OFF = DEF_D1_OFF,
   parameter int unsigned D2_ON  = DEF_D2_ON,
   parameter int unsigned D2_OFF = DEF_D2_OFF,
   parameter int unsigned WE_ON  = DEF_WE_ON,
   parameter int unsigned WE_OFF = DEF_WE_OFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       run,
   input  logic       clk100_en,
   input  logic [1:0] pix_data,
   output logic       sram_we,
   output logic       sram_d1,
   output logic       sram_d2,
   output logic       last_tick
);

   logic [TICK_W-1:0] tick_q, tick_d;
   logic [1:0]        data_q, data_d;
   logic              we_q, we_d, d1_q, d1_d, d2_q, d2_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_q <= '0;
         data_q <= '0;
         we_q   <= 1'b0;
         d1_q   <= 1'b0;
         d2_q   <= 1'b0;
      end else begin
         tick_q <= tick_d;
         data_q <= data_d;
         we_q   <= we_d;
         d1_q   <= d1_d;
         d2_q   <= d2_d;
      end
   end

   always_comb begin
      tick_d = tick_q;
      data_d = data_q;
      if (clear) begin
         tick_d = '0;
         data_d = pix_data;
      end else if (run && clk100_en) begin
         tick_d = tick_q + 1'b1;
      end
      we_d = run && in_window(32'(tick_q), WE_ON, WE_OFF);
      d1_d = run && data_q[0] && in_window(32'(tick_q), D1_ON, D1_OFF);
      d2_d = run && data_q[1] && in_window(32'(tick_q), D2_ON, D2_OFF);
   end

   assign last_tick = run && clk100_en && (tick_q == TICK_W'(WINDOW - 1));
   assign sram_we   = we_q;
   assign sram_d1   = d1_q;
   assign sram_d2   = d2_q;

endmodule

// File: rtl/pixel_sram_write_sequencer.sv
// Frame-level pixel SRAM write scheduler: row/column scan, pixel handshake and
// one timed write window per pixel.
//   IDLE     | waiting for start, addresses held
//   WAIT_PIX | pix_ready high, waiting for pixel data
//   PULSE    | write window playing out
//   NEXT     | advance column/row, detect last pixel
//   DONE     | one-cycle done pulse
module pixel_sram_write_sequencer
   import mea_pkg::*;
#(
   parameter int unsigned ROW_W  = 6,
   parameter int unsigned COL_W  = 6,
   parameter int unsigned TICK_W = 4,
   parameter int unsigned WINDOW = DEF_WINDOW,
   parameter int unsigned D1_ON  = DEF_D1_ON,
   parameter int unsigned D1_OFF = DEF_D1_OFF,
   parameter int unsigned D2_ON  = DEF_D2_ON,
   parameter int unsigned D2_OFF = DEF_D2_OFF,
   parameter int unsigned WE_ON  = DEF_WE_ON,
   parameter int unsigned WE_OFF = DEF_WE_OFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk100_en,
   input  logic             start,
   input  logic             abort,
   input  logic [ROW_W-1:0] num_rows,
   input  logic [COL_W-1:0] num_cols,
   input  logic             pix_valid,
   input  logic [1:0]       pix_data,
   output logic             pix_ready,
   output logic [ROW_W-1:0] row_addr,
   output logic [COL_W-1:0] col_addr,
   output logic             SRAM_WE,
   output logic             SRAM_D1,
   output logic             SRAM_D2,
   output logic             busy,
   output logic             done
);

   if (WINDOW < 1 || WINDOW > (1 << TICK_W) || D1_ON >= D1_OFF || D1_OFF > WINDOW ||
       D2_ON >= D2_OFF || D2_OFF > WINDOW || WE_ON >= WE_OFF || WE_OFF > WINDOW) begin : g_bad_timing
      $error("pixel_sram_write_sequencer: illegal write window timing");
   end

   seq_state_t       state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d, nrows_q, nrows_d;
   logic [COL_W-1:0] col_q, col_d, ncols_q, ncols_d;
   logic             last_col, last_pix, hs, run, last_tick;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         nrows_q <= '0;
         ncols_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         nrows_q <= nrows_d;
         ncols_q <= ncols_d;
      end
   end

   assign last_col = (col_q == ncols_q - COL_W'(1));
   assign last_pix = last_col && (row_q == nrows_q - ROW_W'(1));

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     if (start) state_d = (num_rows == '0 || num_cols == '0) ? DONE : WAIT_PIX;
            WAIT_PIX: if (pix_valid) state_d = PULSE;
            PULSE:    if (last_tick) state_d = NEXT;
            NEXT:     state_d = last_pix ? DONE : WAIT_PIX;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      row_d   = row_q;
      col_d   = col_q;
      nrows_d = nrows_q;
      ncols_d = ncols_q;
      if (abort) begin
         row_d = '0;
         col_d = '0;
      end else if (state_q == IDLE && start) begin
         nrows_d = num_rows;
         ncols_d = num_cols;
         row_d   = '0;
         col_d   = '0;
      end else if (state_q == NEXT && !last_pix) begin
         if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      pix_ready = (state_q == WAIT_PIX);
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      hs        = pix_ready && pix_valid && !abort;
      run       = (state_q == PULSE) && !abort;
   end

   assign row_addr = row_q;
   assign col_addr = col_q;

   pixel_pulse_gen #(
      .TICK_W (TICK_W),
      .WINDOW (WINDOW),
      .D1_ON  (D1_ON),
      .D1_OFF (D1_OFF),
      .D2_ON  (D2_ON),
      .D2_OFF (D2_OFF),
      .WE_ON  (WE_ON),
      .WE_OFF (WE_OFF)
   ) u_pulse (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (hs),
      .run       (run),
      .clk100_en (clk100_en),
      .pix_data  (pix_data),
      .sram_we   (SRAM_WE),
      .sram_d1   (SRAM_D1),
      .sram_d2   (SRAM_D2),
      .last_tick (last_tick)
   );

endmodule

// File: tb/tb_pixel_sram_write_sequencer.sv
// Directed bench for the pixel SRAM write sequencer with a per-pixel scoreboard.
module tb_pixel_sram_write_sequencer;
   import mea_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, clk100_en, start, abort, pix_valid;
   logic [5:0] num_rows, num_cols;
   logic [1:0] pix_data;
   logic       pix_ready, SRAM_WE, SRAM_D1, SRAM_D2, busy, done;
   logic [5:0] row_addr, col_addr;

   pixel_sram_write_sequencer dut (
      .clk(clk), .rst_n(rst_n), .clk100_en(clk100_en), .start(start), .abort(abort),
      .num_rows(num_rows), .num_cols(num_cols), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(pix_ready), .row_addr(row_addr), .col_addr(col_addr), .SRAM_WE(SRAM_WE),
      .SRAM_D1(SRAM_D1), .SRAM_D2(SRAM_D2), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int row;
      int col;
      int we_w;
      int d1_w;
      int d2_w;
      int d1_to_we;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   en_div = 1;
   int   en_ph  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Width in clk of one window line whose window may be cut short at tick `cut`.
   function automatic int exp_w(input int on, input int off, input int cut, input int per);
      int hi;
      hi = (off < cut) ? off : cut;
      return (hi > on) ? (hi - on) * per : 0;
   endfunction

   initial begin
      clk100_en = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         en_ph     = (en_ph + 1 >= en_div) ? 0 : en_ph + 1;
         clk100_en = (en_ph == 0);
      end
   end

   int   cyc = 0, d1_cnt = 0, d2_cnt = 0, we_cnt = 0, we_rise = 0, d1_rise = 0;
   int   cap_row = 0, cap_col = 0, we_pulses = 0, done_pulses = 0;
   logic we_prev = 1'b0;
   exp_t e;

   always @(negedge clk) begin
      cyc++;
      if (rst_n && pix_valid && pix_ready && !abort) begin
         d1_cnt = 0; d2_cnt = 0; we_cnt = 0;
      end else begin
         if (SRAM_D1) begin
            if (d1_cnt == 0) d1_rise = cyc;
            d1_cnt++;
         end
         if (SRAM_D2) d2_cnt++;
         if (SRAM_WE) begin
            if (!we_prev) begin
               we_rise = cyc; cap_row = row_addr; cap_col = col_addr; we_pulses++;
            end
            we_cnt++;
         end
         if (!SRAM_WE && we_prev) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 1);
            end else begin
               e = sb.pop_front();
               chk("pix_row", cap_row, e.row);
               chk("pix_col", cap_col, e.col);
               chk("we_width", we_cnt, e.we_w);
               chk("d1_width", d1_cnt, e.d1_w);
               chk("d2_width", d2_cnt, e.d2_w);
               if (e.d1_w > 0) chk("d1_to_we", we_rise - d1_rise, e.d1_to_we);
            end
         end
      end
      if (done) done_pulses++;
      we_prev = SRAM_WE;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input int r, input int c);
      num_rows = 6'(r);
      num_cols = 6'(c);
      start    = 1'b1;
      step(1);
      start    = 1'b0;
   endtask

   task automatic send_pixel(input int r, input int c, input logic [1:0] d,
                             input int cut, input int per);
      int   n;
      exp_t x;
      n = 0;
      while (!pix_ready && n < 300) begin
         step(1);
         n++;
      end
      chk("ready_wait", pix_ready, 1);
      x.row      = r;
      x.col      = c;
      x.we_w     = exp_w(DEF_WE_ON, DEF_WE_OFF, cut, per);
      x.d1_w     = d[0] ? exp_w(DEF_D1_ON, DEF_D1_OFF, cut, per) : 0;
      x.d2_w     = d[1] ? exp_w(DEF_D2_ON, DEF_D2_OFF, cut, per) : 0;
      x.d1_to_we = (DEF_WE_ON - DEF_D1_ON) * per;
      sb.push_back(x);
      pix_valid = 1'b1;
      pix_data  = d;
      step(1);
      pix_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 500) begin
         step(1);
         n++;
      end
      chk(tag, busy, 0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_we"}, SRAM_WE, 0);
      chk({tag, "_d1"}, SRAM_D1, 0);
      chk({tag, "_d2"}, SRAM_D2, 0);
      chk({tag, "_ready"}, pix_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_row"}, row_addr, 0);
      chk({tag, "_col"}, col_addr, 0);
   endtask

   int   w0, d0, n;
   logic ok;
   logic [5:0] ra, ca;

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = 2'b00;
      num_rows = '0; num_cols = '0;
      step(3);
      chk_quiet("reset");
      rst_n = 1'b1;
      step(2);

      // 1x1 frame, both data lines driven
      d0 = done_pulses; w0 = we_pulses;
      do_start(1, 1);
      chk("t1_busy", busy, 1);
      send_pixel(0, 0, 2'b11, DEF_WINDOW, 1);
      wait_idle("t1_idle");
      chk("t1_done_cnt", done_pulses - d0, 1);
      chk("t1_we_cnt", we_pulses - w0, 1);

      // 2x3 frame, D1 only, with a 20-cycle stall before pixel (1,1)
      d0 = done_pulses; w0 = we_pulses;
      do_start(2, 3);
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (r == 1 && c == 1) begin
               n = 0;
               while (!pix_ready && n < 100) begin
                  step(1);
                  n++;
               end
               ok = pix_ready; ra = row_addr; ca = col_addr;
               repeat (20) begin
                  step(1);
                  if (SRAM_WE || SRAM_D1 || SRAM_D2 || !pix_ready || row_addr !== ra || col_addr !== ca)
                     ok = 1'b0;
               end
               chk("stall_quiet", ok, 1);
               chk("stall_row", row_addr, 1);
               chk("stall_col", col_addr, 1);
            end
            send_pixel(r, c, 2'b01, DEF_WINDOW, 1);
         end
      end
      wait_idle("t2_idle");
      chk("t2_done_cnt", done_pulses - d0, 1);
      chk("t2_we_cnt", we_pulses - w0, 6);

      // tick enable every third clk stretches every pulse by 3
      en_div = 3;
      step(6);
      d0 = done_pulses; w0 = we_pulses;
      do_start(1, 2);
      send_pixel(0, 0, 2'b11, DEF_WINDOW, 3);
      send_pixel(0, 1, 2'b10, DEF_WINDOW, 3);
      wait_idle("t3_idle");
      chk("t3_done_cnt", done_pulses - d0, 1);
      chk("t3_we_cnt", we_pulses - w0, 2);
      en_div = 1;
      step(3);

      // abort at tick 5 of pixel (0,1)
      d0 = done_pulses;
      do_start(2, 3);
      send_pixel(0, 0, 2'b01, DEF_WINDOW, 1);
      send_pixel(0, 1, 2'b01, 5, 1);
      step(5);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk_quiet("abort");
      step(4);
      chk("abort_no_done", done_pulses - d0, 0);
      do_start(1, 1);
      send_pixel(0, 0, 2'b10, DEF_WINDOW, 1);
      wait_idle("t4_idle");
      chk("t4_done_cnt", done_pulses - d0, 1);

      // empty frame
      d0 = done_pulses; w0 = we_pulses;
      do_start(3, 0);
      n = 0;
      while (!done && n < 3) begin
         step(1);
         n++;
      end
      chk("t5_done_seen", done, 1);
      wait_idle("t5_idle");
      chk("t5_done_cnt", done_pulses - d0, 1);
      chk("t5_we_cnt", we_pulses - w0, 0);

      // reset in the middle of a window, together with abort
      do_start(1, 1);
      send_pixel(0, 0, 2'b11, 4, 1);
      step(4);
      rst_n = 1'b0;
      abort = 1'b1;
      step(1);
      chk_quiet("midrst");
      rst_n = 1'b1;
      abort = 1'b0;
      step(3);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
